instr_issuer: RTL and testbench

- Command front-end placed directly upstream of the systolic top level.
- Buffers 71-bit systolic instructions from the host/controller in a small FIFO and screens out malformed ones.
- Issues one instruction at a time over the instr_valid/instr/ack handshake, then waits for done before issuing the next.
- Keeps issue and completion counters and a sticky error flag for host status readout.

---
 rtl/instr_issuer_pkg.sv | 53 +++++
 rtl/instr_fifo.sv | 52 +++++
 rtl/instr_issuer.sv | 107 ++++++++++
 tb/tb_instr_issuer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the systolic instruction issuer: field layout,
// op encodings, FSM states and the malformed-command screen.
package instr_issuer_pkg;

    localparam int unsigned INSTR_W = 71;

    localparam int unsigned OP_MSB           = 70;
    localparam int unsigned OP_LSB           = 68;
    localparam int unsigned UNI_SRC_ADDR_MSB = 67;
    localparam int unsigned UNI_SRC_ADDR_LSB = 58;
    localparam int unsigned UNI_CHANNEL_MSB  = 57;
    localparam int unsigned UNI_CHANNEL_LSB  = 50;
    localparam int unsigned UNI_ROW_MSB      = 49;
    localparam int unsigned UNI_ROW_LSB      = 42;
    localparam int unsigned UNI_COL_MSB      = 41;
    localparam int unsigned UNI_COL_LSB      = 34;
    localparam int unsigned WEI_SRC_ADDR_MSB = 33;
    localparam int unsigned WEI_SRC_ADDR_LSB = 24;
    localparam int unsigned WEI_CHANNEL_MSB  = 23;
    localparam int unsigned WEI_CHANNEL_LSB  = 16;
    localparam int unsigned WEI_ROW_MSB      = 15;
    localparam int unsigned WEI_ROW_LSB      = 8;
    localparam int unsigned WEI_COL_MSB      = 7;
    localparam int unsigned WEI_COL_LSB      = 0;

    // op 0 is reserved and never a legal command
    localparam logic [2:0] OP_NONE = 3'b000;

    typedef struct packed {
        logic [2:0] op;
        logic [9:0] uni_src_addr;
        logic [7:0] uni_channel;
        logic [7:0] uni_row;
        logic [7:0] uni_col;
        logic [9:0] wei_src_addr;
        logic [7:0] wei_channel;
        logic [7:0] wei_row;
        logic [7:0] wei_col;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    function automatic logic is_malformed(input instr_t i);
        return (i.op == OP_NONE)
            || (i.uni_channel == '0) || (i.uni_row == '0) || (i.uni_col == '0)
            || (i.wei_channel == '0) || (i.wei_row == '0) || (i.wei_col == '0);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Parameterised synchronous FIFO with occupancy count; DEPTH must be a power of two.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 71,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/instr_issuer.sv
// Command front-end for the systolic top: screens, queues and issues
// instructions one at a time over instr_valid/ack, waiting for done.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [INSTR_W-1:0] cmd_instr,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    input  logic               ack,
    input  logic               done,
    output logic               busy,
    output logic [CNT_W-1:0]   issued_cnt,
    output logic [CNT_W-1:0]   done_cnt,
    output logic               err,
    input  logic               err_clr
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_t             state;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [INSTR_W-1:0] head;
    logic               accept;
    logic               bad_cmd;
    logic               fifo_push;
    logic               fifo_pop;

    // Ready comes only from the registered count: no bypass when full
    assign cmd_ready = !rst && !fifo_full;
    assign accept    = cmd_valid && cmd_ready;
    assign bad_cmd   = is_malformed(instr_t'(cmd_instr));
    assign fifo_push = accept && !bad_cmd;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE) || (fifo_count != '0);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (cmd_instr),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Issue FSM, counters and sticky error; a new bad push beats err_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            instr       <= '0;
            issued_cnt  <= '0;
            done_cnt    <= '0;
            err         <= 1'b0;
        end else begin
            if (accept && bad_cmd) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        instr       <= head;
                        instr_valid <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        instr_valid <= 1'b0;
                        issued_cnt  <= issued_cnt + CNT_W'(1);
                        if (done) begin
                            done_cnt <= done_cnt + CNT_W'(1);
                            state    <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (done) begin
                        done_cnt <= done_cnt + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed timing scenarios followed by
// randomized traffic checked against a queue-based reference model.
module tb_instr_issuer;
    import instr_issuer_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [INSTR_W-1:0] cmd_instr;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               ack;
    logic               done;
    logic               busy;
    logic [CNT_W-1:0]   issued_cnt;
    logic [CNT_W-1:0]   done_cnt;
    logic               err;
    logic               err_clr;

    int n_total = 0;
    int n_fail  = 0;

    instr_t           q[$];
    logic             err_exp;
    logic [CNT_W-1:0] exp_issued;
    logic [CNT_W-1:0] exp_done;

    instr_issuer #(.DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_instr   (cmd_instr),
        .instr_valid (instr_valid),
        .instr       (instr),
        .ack         (ack),
        .done        (done),
        .busy        (busy),
        .issued_cnt  (issued_cnt),
        .done_cnt    (done_cnt),
        .err         (err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input logic [2:0] op, input logic [7:0] d);
        instr_t c;
        c.op = op;           c.uni_src_addr = 10'h011;
        c.uni_channel = d;   c.uni_row = d;  c.uni_col = d;
        c.wei_src_addr = 10'h155;
        c.wei_channel = d;   c.wei_row = d;  c.wei_col = d;
        return c;
    endfunction

    // Reference screening rule, written from the field definitions
    function automatic bit bad(input instr_t c);
        return c.op == 3'd0 || c.uni_channel == 8'd0 || c.uni_row == 8'd0 || c.uni_col == 8'd0
            || c.wei_channel == 8'd0 || c.wei_row == 8'd0 || c.wei_col == 8'd0;
    endfunction

    function automatic instr_t rand_cmd(input bit make_bad);
        instr_t c;
        c.op           = 3'($urandom_range(1, 7));
        c.uni_src_addr = 10'($urandom);
        c.uni_channel  = 8'($urandom_range(1, 255));
        c.uni_row      = 8'($urandom_range(1, 255));
        c.uni_col      = 8'($urandom_range(1, 255));
        c.wei_src_addr = 10'($urandom);
        c.wei_channel  = 8'($urandom_range(1, 255));
        c.wei_row      = 8'($urandom_range(1, 255));
        c.wei_col      = 8'($urandom_range(1, 255));
        if (make_bad) begin
            case ($urandom_range(0, 6))
                0: c.op = 3'd0;
                1: c.uni_channel = 8'd0;
                2: c.uni_row = 8'd0;
                3: c.uni_col = 8'd0;
                4: c.wei_channel = 8'd0;
                5: c.wei_row = 8'd0;
                default: c.wei_col = 8'd0;
            endcase
        end
        return c;
    endfunction

    // Offer one command, update the model from what the bench drove
    task automatic push(input instr_t c, input bit clr);
        int w;
        w = 0;
        cmd_valid = 1'b1;
        cmd_instr = c;
        while (!cmd_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("push_ready", 80'(cmd_ready), 80'(1'b1));
        err_clr = clr;
        @(negedge clk);
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        if (bad(c)) begin
            err_exp = 1'b1;
        end else begin
            if (clr) err_exp = 1'b0;
            q.push_back(c);
        end
        check("err_flag", 80'(err), 80'(err_exp));
    endtask

    // Act as the systolic top for the next expected instruction
    task automatic serve(input bit same);
        instr_t e;
        int     w;
        int     hold;
        e = q.pop_front();
        w = 0;
        while (!instr_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("issue_valid", 80'(instr_valid), 80'(1'b1));
        check("issue_order", 80'(instr), 80'(e));
        hold = $urandom_range(0, 2);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_stable", 80'({instr_valid, instr}), 80'({1'b1, e}));
        end
        ack  = 1'b1;
        done = same;
        @(negedge clk);
        ack  = 1'b0;
        done = 1'b0;
        exp_issued++;
        if (same) exp_done++;
        check("ack_drop", 80'(instr_valid), 80'(1'b0));
        check("issued_cnt", 80'(issued_cnt), 80'(exp_issued));
        if (!same) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            exp_done++;
        end
        check("done_cnt", 80'(done_cnt), 80'(exp_done));
    endtask

    initial begin
        instr_t a, b, d0, d1, m, e;
        instr_t fc[6];
        int     w;
        int     burst;
        int     valid_pushed;
        bit     mkbad;
        instr_t c;

        rst = 1'b1; cmd_valid = 1'b0; cmd_instr = '0;
        ack = 1'b0; done = 1'b0; err_clr = 1'b0;
        err_exp = 1'b0; exp_issued = '0; exp_done = '0;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_ready", 80'(cmd_ready), 80'(1'b0));
        check("rst_outs", 80'({instr_valid, busy, err, issued_cnt, done_cnt}), 80'(0));
        check("rst_instr", 80'(instr), 80'(0));
        rst = 1'b0;
        @(negedge clk);

        // single command: ack at t+4, done at t+20
        a = mk(3'b001, 8'd8);
        cmd_valid = 1'b1; cmd_instr = a;
        check("single_ready", 80'(cmd_ready), 80'(1'b1));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("single_t1", 80'({busy, instr_valid}), 80'(2'b10));
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check("single_req", 80'({instr_valid, instr}), 80'({1'b1, a}));
            if (k == 4) ack = 1'b1;
        end
        @(negedge clk);
        ack = 1'b0;
        exp_issued++;
        check("single_t5", 80'({instr_valid, issued_cnt}), 80'({1'b0, exp_issued}));
        repeat (15) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        exp_done++;
        check("single_done", 80'(done_cnt), 80'(exp_done));
        check("single_idle", 80'(busy), 80'(1'b0));
        check("single_retain", 80'(instr), 80'(a));

        // spurious done in IDLE and in REQ
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("spur_idle", 80'({issued_cnt, done_cnt}), 80'({exp_issued, exp_done}));
        b = mk(3'b010, 8'd3);
        cmd_valid = 1'b1; cmd_instr = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("spur_req", 80'({instr_valid, done_cnt}), 80'({1'b1, exp_done}));
        q.push_back(b);
        serve(1'b0);

        // fill: five back-to-back pushes with ack low
        for (int k = 0; k < 6; k++) fc[k] = mk(3'(k % 7 + 1), 8'(k + 3));
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1; cmd_instr = fc[k];
            check("fill_ready", 80'(cmd_ready), 80'(1'b1));
            @(negedge clk);
        end
        cmd_instr = fc[5];
        check("fill_full", 80'(cmd_ready), 80'(1'b0));
        check("fill_head", 80'({instr_valid, instr}), 80'({1'b1, fc[0]}));
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("fill_wait_full", 80'(cmd_ready), 80'(1'b0));
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("fill_no_bypass", 80'(cmd_ready), 80'(1'b0));
        @(negedge clk);
        check("fill_resume", 80'(cmd_ready), 80'(1'b1));
        @(negedge clk);
        cmd_valid = 1'b0;
        exp_issued++; exp_done++;
        check("fill_cnts", 80'({issued_cnt, done_cnt}), 80'({exp_issued, exp_done}));
        for (int k = 1; k < 6; k++) q.push_back(fc[k]);
        for (int k = 1; k < 6; k++) serve(1'b0);

        // malformed commands
        m = mk(3'b001, 8'd8); m.wei_row = 8'd0;
        push(m, 1'b0);
        m = mk(3'b000, 8'd8);
        push(m, 1'b0);
        repeat (3) @(negedge clk);
        check("bad_not_issued", 80'({instr_valid, busy, issued_cnt}), 80'({2'b00, exp_issued}));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        err_exp = 1'b0;
        check("err_clear", 80'(err), 80'(err_exp));
        m = mk(3'b011, 8'd5); m.uni_col = 8'd0;
        push(m, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        err_exp = 1'b0;

        // same-cycle ack && done with two queued
        d0 = mk(3'b100, 8'd7);
        d1 = mk(3'b101, 8'd9);
        cmd_valid = 1'b1; cmd_instr = d0;
        @(negedge clk);
        cmd_instr = d1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ad_first", 80'({instr_valid, instr}), 80'({1'b1, d0}));
        ack = 1'b1; done = 1'b1;
        @(negedge clk);
        ack = 1'b0; done = 1'b0;
        exp_issued++; exp_done++;
        check("ad_gap", 80'({instr_valid, busy}), 80'(2'b01));
        check("ad_cnts", 80'({issued_cnt, done_cnt}), 80'({exp_issued, exp_done}));
        @(negedge clk);
        check("ad_second", 80'({instr_valid, instr}), 80'({1'b1, d1}));
        q.push_back(d1);
        serve(1'b0);

        // reset while waiting for done, then a stale done
        e = mk(3'b110, 8'd2);
        push(e, 1'b0);
        w = 0;
        while (!instr_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("mid_busy", 80'({instr_valid, busy}), 80'(2'b01));
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 80'(cmd_ready), 80'(1'b0));
        @(negedge clk);
        check("mid_rst_outs", 80'({instr_valid, busy, err, issued_cnt, done_cnt}), 80'(0));
        check("mid_rst_instr", 80'(instr), 80'(0));
        rst = 1'b0; done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        q.delete();
        exp_issued = '0; exp_done = '0; err_exp = 1'b0;
        check("stale_done", 80'({instr_valid, busy, done_cnt}), 80'({2'b00, exp_done}));

        // randomized traffic: exactly 16 well-formed commands wrap the 4-bit counters
        valid_pushed = 0;
        while (valid_pushed < 16) begin
            burst = $urandom_range(1, 3);
            for (int k = 0; k < burst && valid_pushed < 16; k++) begin
                mkbad = ($urandom_range(0, 3) == 0);
                c = rand_cmd(mkbad);
                push(c, $urandom_range(0, 4) == 0);
                if (!bad(c)) valid_pushed++;
            end
            while (q.size() > 0) serve(1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        check("wrap_done", 80'(done_cnt), 80'(exp_done));
        check("wrap_issued", 80'(issued_cnt), 80'(exp_issued));
        check("end_idle", 80'(busy), 80'(1'b0));

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
